// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO read side.
// Contents:
//   gray_word_t  - wide working type for pointer conversions; callers cast
//                  their pointer into it and cast the result back to width
//   occ_e        - occupancy states of the 2-entry prefetch buffer
//   bin2gray     - binary to reflected Gray code
//   gray2bin     - reflected Gray code to binary
package fifo_pkg;

   // Conversions run on a 32-bit word so that any pointer width up to 32 bits
   // can share one function. Zero-extended upper bits stay zero in both
   // directions, so truncating the result back gives the right answer.
   typedef logic [31:0] gray_word_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Bus bundle between the FIFO read controller and its surroundings.
// Carries the RAM read port (raddr, ren, rdata) and the consumer handshake
// (dout, dout_valid, dout_ready).
//   master - the read controller: drives raddr/ren/dout/dout_valid
//   slave  - RAM and consumer: drive rdata and dout_ready
interface fifo_rd_ctrl_if #(
   parameter int ADDRSIZE = 8,
   parameter int DATASIZE = 8
);
   logic [ADDRSIZE-1:0] raddr;
   logic                ren;
   logic [DATASIZE-1:0] rdata;
   logic [DATASIZE-1:0] dout;
   logic                dout_valid;
   logic                dout_ready;

   modport master (
      output raddr, ren, dout, dout_valid,
      input  rdata, dout_ready
   );

   modport slave (
      input  raddr, ren, dout, dout_valid,
      output rdata, dout_ready
   );
endinterface

// File: rtl/fifo_rd_ptr.sv
// Read pointer, empty flag and fill count for the FIFO read domain.
// Ports:
//   rclk      - read clock
//   rrst_n    - synchronous active-low reset
//   ren       - a RAM read is issued this clock; advances the pointer
//   rq2_wptr  - write pointer (Gray) already synchronized into rclk
//   rptr      - registered Gray read pointer for the write-side synchronizer
//   raddr     - binary RAM address (low bits of the binary pointer)
//   rempty    - registered empty flag
//   rd_count  - registered count of words in RAM not yet read
module fifo_rd_ptr
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = 8
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                ren,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   output logic [ADDRSIZE:0]   rptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic                rempty,
   output logic [ADDRSIZE:0]   rd_count
);

   localparam int PW = ADDRSIZE + 1;

   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] rbnext;
   logic [ADDRSIZE:0] rgnext;
   logic [ADDRSIZE:0] wbin;

   // Next pointer values. The extra MSB lets full and empty be told apart:
   // equal Gray pointers mean empty, so wrap needs no special handling.
   always_comb begin
      rbnext = rbin + PW'(ren);
      rgnext = PW'(bin2gray(gray_word_t'(rbnext)));
      wbin   = PW'(gray2bin(gray_word_t'(rq2_wptr)));
   end

   // Pointer and flag registers. Empty compares against the synchronized
   // write pointer as sampled now, so a write landing on the same clock only
   // shows up one clock later (stale empty, never a false not-empty).
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rbin     <= '0;
         rptr     <= '0;
         rempty   <= 1'b1;
         rd_count <= '0;
      end else begin
         rbin     <= rbnext;
         rptr     <= rgnext;
         rempty   <= (rgnext == rq2_wptr);
         rd_count <= wbin - rbnext;
      end
   end

   assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO, entirely in the rclk domain.
// Issues RAM reads, owns the read pointer, and presents data through a
// 2-entry prefetch buffer (head = dout, plus one skid entry) so a consumer
// holding dout_ready high receives one word per clock.
// Ports:
//   rclk      - read clock, the only clock here
//   rrst_n    - synchronous active-low reset; discards buffered/in-flight words
//   rq2_wptr  - synchronized write pointer, Gray code
//   rptr      - registered Gray read pointer to the write-side synchronizer
//   rempty    - registered empty flag of the RAM side
//   rd_count  - registered, conservative count of unread RAM words
//   bus       - master side of fifo_rd_ctrl_if (RAM read port + consumer handshake)
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = 8,
   parameter int DATASIZE = 8
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic [ADDRSIZE:0] rq2_wptr,
   output logic [ADDRSIZE:0] rptr,
   output logic              rempty,
   output logic [ADDRSIZE:0] rd_count,
   fifo_rd_ctrl_if.master    bus
);

   occ_e                occ_q;
   occ_e                occ_d;
   logic [DATASIZE-1:0] dout_q;
   logic [DATASIZE-1:0] dout_d;
   logic [DATASIZE-1:0] skid_q;
   logic [DATASIZE-1:0] skid_d;
   logic                inflight_q;
   logic                pop;
   logic                ren;
   logic [2:0]          level;

   fifo_rd_ptr #(
      .ADDRSIZE (ADDRSIZE)
   ) u_rd_ptr (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .ren      (ren),
      .rq2_wptr (rq2_wptr),
      .rptr     (rptr),
      .raddr    (bus.raddr),
      .rempty   (rempty),
      .rd_count (rd_count)
   );

   // Read issue. level is how many words the buffer will hold after this
   // clock if nothing new is read; a read is only issued when that leaves
   // room, which is what guarantees no word ever arrives while already full.
   always_comb begin
      pop   = (occ_q != OCC_EMPTY) && bus.dout_ready;
      level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      ren   = !rempty && (level < 3'd2);
   end

   // Prefetch buffer next state. An arrival is the RAM word for a read issued
   // last clock. With two words held, a pop promotes the skid entry to head.
   always_comb begin
      occ_d  = occ_q;
      dout_d = dout_q;
      skid_d = skid_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (inflight_q) begin
               occ_d  = OCC_ONE;
               dout_d = bus.rdata;
            end
         end
         OCC_ONE: begin
            if (inflight_q && pop) begin
               dout_d = bus.rdata;
            end else if (inflight_q) begin
               occ_d  = OCC_TWO;
               skid_d = bus.rdata;
            end else if (pop) begin
               occ_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               occ_d  = OCC_ONE;
               dout_d = skid_q;
            end
         end
         default: begin
            occ_d = OCC_EMPTY;
         end
      endcase
   end

   // Buffer registers. Clearing inflight_q on reset is what drops the RAM
   // return of any read issued just before reset.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         occ_q      <= OCC_EMPTY;
         dout_q     <= '0;
         skid_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         dout_q     <= dout_d;
         skid_q     <= skid_d;
         inflight_q <= ren;
      end
   end

   // A word arriving while both entries are occupied would be lost.
   assert property (@(posedge rclk) disable iff (!rrst_n)
      !((occ_q == OCC_TWO) && inflight_q));

   assign bus.ren        = ren;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = (occ_q != OCC_EMPTY);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with ADDRSIZE=2, DATASIZE=8.
// A 4-entry RAM model with one clock of read latency sits on the bus; the
// bench plays the write side by filling RAM and publishing rq2_wptr.
module tb_fifo_rd_ctrl;

   localparam int ADDRSIZE = 2;
   localparam int DATASIZE = 8;

   logic       rclk = 1'b0;
   logic       rrst_n;
   logic [2:0] rq2_wptr;
   logic [2:0] rptr;
   logic       rempty;
   logic [2:0] rd_count;

   fifo_rd_ctrl_if #(.ADDRSIZE(ADDRSIZE), .DATASIZE(DATASIZE)) bus ();

   fifo_rd_ctrl #(
      .ADDRSIZE (ADDRSIZE),
      .DATASIZE (DATASIZE)
   ) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rq2_wptr (rq2_wptr),
      .rptr     (rptr),
      .rempty   (rempty),
      .rd_count (rd_count),
      .bus      (bus)
   );

   always #5 rclk = ~rclk;

   // RAM model: data for a read issued this clock appears after the edge.
   logic [7:0] ram [4];
   always @(posedge rclk) begin
      if (bus.ren === 1'b1) bus.rdata <= ram[bus.raddr];
   end

   int         testCount = 0;
   int         failCount = 0;
   logic [7:0] expQ [$];
   logic [2:0] wbin;
   int         renCount;

   function automatic logic [2:0] toGray(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // All sampling and driving happens 2 time units after the rising edge.
   task automatic waitCycle();
      @(posedge rclk);
      #2;
   endtask

   task automatic writeWord(input logic [7:0] val);
      ram[wbin[1:0]] = val;
      expQ.push_back(val);
      wbin = wbin + 3'd1;
   endtask

   task automatic applyStimulus(input int cycles);
      rrst_n          = 1'b0;
      rq2_wptr        = 3'b000;
      wbin            = 3'b000;
      bus.dout_ready  = 1'b0;
      expQ.delete();
      repeat (cycles) waitCycle();
      rrst_n = 1'b1;
   endtask

   // Consumer loop with optional concurrent writer; compares every popped
   // word against the queue and gives up after the cycle budget.
   task automatic runTraffic(input int popTarget, input int budget,
                             input bit randomReady, input int writeTarget);
      int         got   = 0;
      int         wrote = 0;
      int         cyc   = 0;
      logic [7:0] expWord;
      while (got < popTarget && cyc < budget) begin
         if (wrote < writeTarget && (wrote - got) < 4 && $urandom_range(0, 1) == 1) begin
            writeWord(8'($urandom_range(0, 255)));
            wrote++;
            rq2_wptr = toGray(wbin);
         end
         bus.dout_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         checkOutput("noReadWhenEmpty", 32'(bus.ren & rempty), 32'h0);
         if (bus.dout_valid && bus.dout_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedWord", 32'(bus.dout), 32'hFFFF_FFFF);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("drainData", 32'(bus.dout), 32'(expWord));
            end
            got++;
         end
         waitCycle();
         cyc++;
      end
      checkOutput("drainCount", 32'(got), 32'(popTarget));
   endtask

   initial begin
      // Reset held with a nonzero write pointer: outputs stay idle.
      rrst_n         = 1'b0;
      rq2_wptr       = 3'b010;
      wbin           = 3'b000;
      bus.dout_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         waitCycle();
         checkOutput("rstEmpty", 32'(rempty), 32'h1);
         checkOutput("rstRptr", 32'(rptr), 32'h0);
         checkOutput("rstValid", 32'(bus.dout_valid), 32'h0);
         checkOutput("rstRen", 32'(bus.ren), 32'h0);
         checkOutput("rstCount", 32'(rd_count), 32'h0);
         checkOutput("rstDout", 32'(bus.dout), 32'h0);
      end
      rq2_wptr = 3'b000;
      rrst_n   = 1'b1;
      waitCycle();
      checkOutput("idleEmpty", 32'(rempty), 32'h1);
      checkOutput("idleRen", 32'(bus.ren), 32'h0);

      // Single word: 3 clocks from pointer update to dout.
      writeWord(8'hA5);
      rq2_wptr       = toGray(wbin);
      bus.dout_ready = 1'b1;
      waitCycle();
      checkOutput("swEmptyLow", 32'(rempty), 32'h0);
      checkOutput("swRen", 32'(bus.ren), 32'h1);
      checkOutput("swCount", 32'(rd_count), 32'h1);
      checkOutput("swRaddr0", 32'(bus.raddr), 32'h0);
      checkOutput("swValid0", 32'(bus.dout_valid), 32'h0);
      waitCycle();
      checkOutput("swRptr", 32'(rptr), 32'h1);
      checkOutput("swEmptyAgain", 32'(rempty), 32'h1);
      checkOutput("swRenOff", 32'(bus.ren), 32'h0);
      checkOutput("swRaddr1", 32'(bus.raddr), 32'h1);
      checkOutput("swCountZero", 32'(rd_count), 32'h0);
      waitCycle();
      checkOutput("swValid", 32'(bus.dout_valid), 32'h1);
      checkOutput("swData", 32'(bus.dout), 32'hA5);
      waitCycle();
      checkOutput("swPopped", 32'(bus.dout_valid), 32'h0);

      // Backpressure from a fresh pointer: only two reads fill the buffer.
      applyStimulus(1);
      waitCycle();
      writeWord(8'h11);
      writeWord(8'h22);
      writeWord(8'h33);
      writeWord(8'h44);
      rq2_wptr = toGray(wbin);
      renCount = 0;
      for (int i = 0; i < 6; i++) begin
         waitCycle();
         renCount += int'(bus.ren);
         if (i >= 2) begin
            checkOutput("bpHoldValid", 32'(bus.dout_valid), 32'h1);
            checkOutput("bpHoldData", 32'(bus.dout), 32'h11);
         end
      end
      checkOutput("bpReadCount", 32'(renCount), 32'h2);
      checkOutput("bpRptr", 32'(rptr), 32'h3);
      checkOutput("bpCount", 32'(rd_count), 32'h2);
      bus.dout_ready = 1'b1;
      waitCycle();
      checkOutput("bpData22", 32'(bus.dout), 32'h22);
      waitCycle();
      checkOutput("bpData33", 32'(bus.dout), 32'h33);
      checkOutput("bpEmpty", 32'(rempty), 32'h1);
      waitCycle();
      checkOutput("bpData44", 32'(bus.dout), 32'h44);
      checkOutput("bpValid44", 32'(bus.dout_valid), 32'h1);
      waitCycle();
      checkOutput("bpDrained", 32'(bus.dout_valid), 32'h0);
      checkOutput("bpRptrEnd", 32'(rptr), 32'h6);

      // Wrap and full: advance the read pointer to binary 7, then queue four
      // words so the write pointer wraps to binary 3.
      expQ.delete();
      writeWord(8'h50);
      writeWord(8'h51);
      writeWord(8'h52);
      rq2_wptr = toGray(wbin);
      runTraffic(3, 20, 1'b0, 0);
      waitCycle();
      checkOutput("preRptr", 32'(rptr), 32'h4);
      checkOutput("preEmpty", 32'(rempty), 32'h1);
      bus.dout_ready = 1'b0;
      writeWord(8'hA0);
      writeWord(8'hA1);
      writeWord(8'hA2);
      writeWord(8'hA3);
      rq2_wptr = toGray(wbin);
      waitCycle();
      checkOutput("fullCount", 32'(rd_count), 32'h4);
      checkOutput("fullNotEmpty", 32'(rempty), 32'h0);
      runTraffic(4, 20, 1'b0, 0);
      waitCycle();
      checkOutput("wrapRptr", 32'(rptr), 32'h2);
      checkOutput("wrapEmpty", 32'(rempty), 32'h1);
      checkOutput("wrapCount", 32'(rd_count), 32'h0);
      checkOutput("wrapValid", 32'(bus.dout_valid), 32'h0);

      // Reset with both entries full and a read being issued.
      expQ.delete();
      bus.dout_ready = 1'b0;
      writeWord(8'hC0);
      writeWord(8'hC1);
      writeWord(8'hC2);
      rq2_wptr = toGray(wbin);
      repeat (5) waitCycle();
      checkOutput("mrValid", 32'(bus.dout_valid), 32'h1);
      checkOutput("mrHead", 32'(bus.dout), 32'hC0);
      checkOutput("mrCount", 32'(rd_count), 32'h1);
      bus.dout_ready = 1'b1;
      rrst_n         = 1'b0;
      rq2_wptr       = 3'b000;
      #1;
      checkOutput("mrRenBefore", 32'(bus.ren), 32'h1);
      waitCycle();
      checkOutput("mrValidRst", 32'(bus.dout_valid), 32'h0);
      checkOutput("mrRptrRst", 32'(rptr), 32'h0);
      checkOutput("mrEmptyRst", 32'(rempty), 32'h1);
      checkOutput("mrDoutRst", 32'(bus.dout), 32'h0);
      rrst_n = 1'b1;
      wbin   = 3'b000;
      expQ.delete();
      waitCycle();
      checkOutput("mrNoStale", 32'(bus.dout_valid), 32'h0);
      checkOutput("mrEmptyAfter", 32'(rempty), 32'h1);
      checkOutput("mrRenAfter", 32'(bus.ren), 32'h0);

      // Random traffic: concurrent writer and 50% consumer readiness.
      runTraffic(200, 3000, 1'b1, 200);
      waitCycle();
      waitCycle();
      checkOutput("rndEmpty", 32'(rempty), 32'h1);
      checkOutput("rndValid", 32'(bus.dout_valid), 32'h0);
      checkOutput("rndRptr", 32'(rptr), 32'(toGray(wbin)));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
